// File: rtl/l2_fill_pkg.sv
// Shared definitions for the L2 DDR refill engine: FSM encoding and L2 geometry.
`default_nettype none

package l2_fill_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    REQ        = 2'd2,
    RECV       = 2'd3
  } fill_state_t;

  localparam int L2_WORDS       = 4096;
  localparam int WORDS_PER_BEAT = 8;
  localparam int BYTES_PER_BEAT = 16;

endpackage

`default_nettype wire

// File: rtl/l2_fill_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is presented combinationally.
`default_nettype none

module l2_fill_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (!push_ok && pop_ok) count <= count - 1'b1;
    end
  end

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  // Head reads as zero when empty so the data port is quiet after reset.
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/l2_ddr_refill_ctrl.sv
// DDR-side fill engine: throttled burst reads into a skid FIFO, drained into the L2 DDR port.
`default_nettype none

module l2_ddr_refill_ctrl
  import l2_fill_pkg::*;
#(
  parameter int BURST_BEATS = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = 28
) (
  input  logic              clk_166M66,
  input  logic              mcu_sys_rst,
  input  logic              i_fetch_start,
  input  logic              i_fetch_stop,
  input  logic [ADDR_W-1:0] i_fetch_base_addr,
  input  logic [11:0]       i_l2_unread_size,
  input  logic              i_l1ddr_rw_conflicts,
  output logic              o_ddr_rd_req,
  output logic [ADDR_W-1:0] o_ddr_rd_addr,
  output logic [4:0]        o_ddr_rd_len,
  input  logic              i_ddr_rd_ack,
  input  logic              i_ddr_rd_valid,
  input  logic [127:0]      i_ddr_rd_data,
  input  logic              i_ddr_rd_last,
  output logic              o_l2_ddr_operate_enable,
  output logic              o_l2_ddr_rw,
  output logic [127:0]      o_l2_ddr_data,
  output logic              o_busy,
  output logic              o_err,
  output logic [15:0]       o_lines_fetched
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fill_state_t      state;
  fill_state_t      next_state;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        beat_cnt;
  logic              stop_pending;
  logic              stop_eff;
  logic              err;
  logic [15:0]       lines_fetched;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              drain_en;
  logic [12:0]       space_free;
  logic [12:0]       space_need;
  logic              space_ok;
  logic              fifo_ok;

  assign push     = i_ddr_rd_valid && (state == RECV);
  assign drain_en = !fifo_empty && !i_l1ddr_rw_conflicts;
  assign stop_eff = stop_pending || i_fetch_stop;

  // Space is counted in 16-bit L2 words: one beat occupies eight of them.
  assign space_free = 13'(L2_WORDS - 1) - {1'b0, i_l2_unread_size};
  assign space_need = 13'(WORDS_PER_BEAT) * (13'(fifo_count) + 13'(BURST_BEATS));
  assign space_ok   = (space_free >= space_need);
  assign fifo_ok    = (fifo_count <= CNT_W'(FIFO_DEPTH - BURST_BEATS));

  l2_fill_fifo #(
    .WIDTH (128),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_166M66),
    .rst   (mcu_sys_rst),
    .push  (push),
    .din   (i_ddr_rd_data),
    .pop   (drain_en),
    .dout  (o_l2_ddr_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state    = state;
    o_ddr_rd_req  = 1'b0;
    o_ddr_rd_addr = '0;
    o_ddr_rd_len  = '0;
    unique case (state)
      IDLE: begin
        if (i_fetch_start) next_state = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (stop_eff)                 next_state = IDLE;
        else if (space_ok && fifo_ok) next_state = REQ;
      end
      REQ: begin
        o_ddr_rd_req  = 1'b1;
        o_ddr_rd_addr = addr;
        o_ddr_rd_len  = 5'(BURST_BEATS);
        if (i_ddr_rd_ack) next_state = RECV;
      end
      RECV: begin
        if (i_ddr_rd_valid && i_ddr_rd_last) next_state = stop_eff ? IDLE : WAIT_SPACE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      addr          <= '0;
      beat_cnt      <= '0;
      stop_pending  <= 1'b0;
      err           <= 1'b0;
      lines_fetched <= '0;
    end else begin
      if (state == IDLE && i_fetch_start)
        addr <= i_fetch_base_addr & ~ADDR_W'(15);
      else if (state == REQ && i_ddr_rd_ack)
        addr <= addr + ADDR_W'(BURST_BEATS * BYTES_PER_BEAT);

      if (state == REQ && i_ddr_rd_ack) beat_cnt <= '0;
      else if (push)                    beat_cnt <= beat_cnt + 1'b1;

      if (state != IDLE && next_state == IDLE) stop_pending <= 1'b0;
      else if (state != IDLE && i_fetch_stop)  stop_pending <= 1'b1;

      if ((i_ddr_rd_valid && state != RECV) || (push && fifo_full) ||
          (push && i_ddr_rd_last && beat_cnt != 5'(BURST_BEATS - 1)))
        err <= 1'b1;

      if (drain_en) lines_fetched <= lines_fetched + 1'b1;
    end
  end

  assign o_l2_ddr_operate_enable = drain_en;
  assign o_l2_ddr_rw             = drain_en;
  assign o_busy                  = (state != IDLE) || !fifo_empty;
  assign o_err                   = err;
  assign o_lines_fetched         = lines_fetched;

endmodule

`default_nettype wire

// File: tb/tb_l2_ddr_refill_ctrl.sv
// Directed self-checking bench for l2_ddr_refill_ctrl with a simple DDR read responder.
`default_nettype none
`timescale 1ns/1ps

module tb_l2_ddr_refill_ctrl;

  logic         clk_166M66 = 1'b0;
  logic         mcu_sys_rst;
  logic         i_fetch_start;
  logic         i_fetch_stop;
  logic [27:0]  i_fetch_base_addr;
  logic [11:0]  i_l2_unread_size;
  logic         i_l1ddr_rw_conflicts;
  logic         o_ddr_rd_req;
  logic [27:0]  o_ddr_rd_addr;
  logic [4:0]   o_ddr_rd_len;
  logic         i_ddr_rd_ack;
  logic         i_ddr_rd_valid;
  logic [127:0] i_ddr_rd_data;
  logic         i_ddr_rd_last;
  logic         o_l2_ddr_operate_enable;
  logic         o_l2_ddr_rw;
  logic [127:0] o_l2_ddr_data;
  logic         o_busy;
  logic         o_err;
  logic [15:0]  o_lines_fetched;

  int tests_run    = 0;
  int tests_failed = 0;
  int next_k       = 0;
  int bad_en       = 0;
  int rw_mismatch  = 0;
  int peak         = 0;
  logic [127:0] l2_q[$];
  logic [127:0] exp_q[$];

  always #3 clk_166M66 = ~clk_166M66;

  l2_ddr_refill_ctrl dut (
    .clk_166M66              (clk_166M66),
    .mcu_sys_rst             (mcu_sys_rst),
    .i_fetch_start           (i_fetch_start),
    .i_fetch_stop            (i_fetch_stop),
    .i_fetch_base_addr       (i_fetch_base_addr),
    .i_l2_unread_size        (i_l2_unread_size),
    .i_l1ddr_rw_conflicts    (i_l1ddr_rw_conflicts),
    .o_ddr_rd_req            (o_ddr_rd_req),
    .o_ddr_rd_addr           (o_ddr_rd_addr),
    .o_ddr_rd_len            (o_ddr_rd_len),
    .i_ddr_rd_ack            (i_ddr_rd_ack),
    .i_ddr_rd_valid          (i_ddr_rd_valid),
    .i_ddr_rd_data           (i_ddr_rd_data),
    .i_ddr_rd_last           (i_ddr_rd_last),
    .o_l2_ddr_operate_enable (o_l2_ddr_operate_enable),
    .o_l2_ddr_rw             (o_l2_ddr_rw),
    .o_l2_ddr_data           (o_l2_ddr_data),
    .o_busy                  (o_busy),
    .o_err                   (o_err),
    .o_lines_fetched         (o_lines_fetched)
  );

  // L2 write-port observer.
  always @(posedge clk_166M66) begin
    if (o_l2_ddr_operate_enable) begin
      l2_q.push_back(o_l2_ddr_data);
      if (i_l1ddr_rw_conflicts) bad_en++;
    end
    if (o_l2_ddr_rw !== o_l2_ddr_operate_enable) rw_mismatch++;
    if (int'(dut.u_fifo.count) > peak) peak = int'(dut.u_fifo.count);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] beat(input int k);
    return {32'hDEAD_0000 + 32'(k), 32'(k), ~32'(k), 32'h1234_0000 + 32'(k)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_166M66);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req"},   128'(o_ddr_rd_req), 0);
    check({tag, "_addr"},  128'(o_ddr_rd_addr), 0);
    check({tag, "_len"},   128'(o_ddr_rd_len), 0);
    check({tag, "_en"},    128'(o_l2_ddr_operate_enable), 0);
    check({tag, "_rw"},    128'(o_l2_ddr_rw), 0);
    check({tag, "_data"},  o_l2_ddr_data, 0);
    check({tag, "_busy"},  128'(o_busy), 0);
    check({tag, "_err"},   128'(o_err), 0);
    check({tag, "_lines"}, 128'(o_lines_fetched), 0);
  endtask

  task automatic do_reset();
    mcu_sys_rst = 1'b1;
    i_fetch_start = 0; i_fetch_stop = 0; i_fetch_base_addr = '0;
    i_l2_unread_size = '0; i_l1ddr_rw_conflicts = 0;
    i_ddr_rd_ack = 0; i_ddr_rd_valid = 0; i_ddr_rd_data = '0; i_ddr_rd_last = 0;
    tick();
    tick();
    mcu_sys_rst = 1'b0;
    l2_q.delete();
    exp_q.delete();
    bad_en = 0; rw_mismatch = 0; peak = 0;
  endtask

  task automatic start(input logic [27:0] base);
    i_fetch_base_addr = base;
    i_fetch_start = 1'b1;
    tick();
    i_fetch_start = 1'b0;
  endtask

  task automatic pulse_stop();
    i_fetch_stop = 1'b1;
    tick();
    i_fetch_stop = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !o_ddr_rd_req; i++) tick();
    check(tag, 128'(o_ddr_rd_req), 1);
  endtask

  task automatic no_req(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_ddr_rd_req) seen++;
      tick();
    end
    check(tag, 128'(seen), 0);
  endtask

  task automatic ack_req(input int delay);
    repeat (delay) tick();
    i_ddr_rd_ack = 1'b1;
    tick();
    i_ddr_rd_ack = 1'b0;
  endtask

  // Drives n back-to-back beats; last on index last_idx; conflict held over [c_lo, c_hi].
  task automatic send_beats(input int n, input int last_idx, input int c_lo, input int c_hi,
                            input bit expect_kept);
    for (int i = 0; i < n; i++) begin
      i_ddr_rd_valid = 1'b1;
      i_ddr_rd_data  = beat(next_k);
      i_ddr_rd_last  = (i == last_idx);
      i_l1ddr_rw_conflicts = (i >= c_lo) && (i <= c_hi);
      if (expect_kept) exp_q.push_back(beat(next_k));
      next_k++;
      tick();
    end
    i_ddr_rd_valid = 0; i_ddr_rd_last = 0; i_l1ddr_rw_conflicts = 0;
  endtask

  task automatic check_delivery(input string tag);
    check({tag, "_count"}, 128'(l2_q.size()), 128'(exp_q.size()));
    if (l2_q.size() == exp_q.size())
      for (int i = 0; i < exp_q.size(); i++) check({tag, "_beat"}, l2_q[i], exp_q[i]);
  endtask

  initial begin
    mcu_sys_rst = 1'b1;
    do_reset();
    mcu_sys_rst = 1'b1;
    tick();
    check_quiet("reset");
    mcu_sys_rst = 1'b0;

    // Basic fill
    do_reset();
    start(28'h001_0008);
    wait_req("basic_req", 10);
    check("basic_addr", 128'(o_ddr_rd_addr), 128'h001_0000);
    check("basic_len", 128'(o_ddr_rd_len), 8);
    ack_req(2);
    check("basic_req_drop", 128'(o_ddr_rd_req), 0);
    send_beats(8, 7, -1, -1, 1);
    repeat (4) tick();
    check_delivery("basic");
    check("basic_lines", 128'(o_lines_fetched), 8);
    wait_req("basic_req2", 10);
    check("basic_addr2", 128'(o_ddr_rd_addr), 128'h001_0080);
    check("basic_rw", 128'(rw_mismatch), 0);

    // Space throttle
    do_reset();
    i_l2_unread_size = 12'd4030;
    start(28'h000_1000);
    wait_req("thr_4030", 10);
    do_reset();
    i_l2_unread_size = 12'd4040;
    start(28'h000_1000);
    no_req("thr_4040", 20);
    i_l2_unread_size = 12'd4032;
    no_req("thr_4032", 10);
    i_l2_unread_size = 12'd4031;
    wait_req("thr_4031", 10);

    // Conflict stall
    do_reset();
    start(28'h000_2000);
    wait_req("cfl_req", 10);
    ack_req(0);
    send_beats(8, 7, 1, 5, 1);
    repeat (12) tick();
    check_delivery("cfl");
    check("cfl_en_in_conflict", 128'(bad_en), 0);
    check("cfl_peak_le8", 128'(peak <= 8), 1);
    check("cfl_err", 128'(o_err), 0);

    // Stop mid-burst
    do_reset();
    start(28'h000_3000);
    wait_req("stop_req", 10);
    ack_req(1);
    send_beats(3, -1, -1, -1, 1);
    pulse_stop();
    send_beats(5, 4, -1, -1, 1);
    no_req("stop_no_req", 20);
    check_delivery("stop");
    check("stop_busy", 128'(o_busy), 0);

    // Protocol errors
    do_reset();
    start(28'h000_4000);
    wait_req("err_req", 10);
    ack_req(0);
    send_beats(5, 4, -1, -1, 1);
    check("err_short_last", 128'(o_err), 1);
    wait_req("err_back_to_wait", 10);
    pulse_stop();
    ack_req(0);
    send_beats(8, 7, -1, -1, 1);
    tick();
    send_beats(1, 0, -1, -1, 0);
    repeat (12) tick();
    check_delivery("err");
    check("err_sticky", 128'(o_err), 1);
    check("err_idle_busy", 128'(o_busy), 0);

    // Reset during RECV, then address wrap
    do_reset();
    start(28'h000_5000);
    wait_req("rst_req", 10);
    ack_req(0);
    send_beats(3, -1, -1, -1, 1);
    send_beats(2, -1, 0, 1, 1);
    i_l1ddr_rw_conflicts = 1'b1;
    tick();
    i_l1ddr_rw_conflicts = 1'b0;
    mcu_sys_rst = 1'b1;
    tick();
    check_quiet("midrst");
    do_reset();
    start(28'hFFF_FFC0);
    wait_req("wrap_req", 10);
    check("wrap_addr1", 128'(o_ddr_rd_addr), 128'hFFF_FFC0);
    ack_req(0);
    send_beats(8, 7, -1, -1, 1);
    wait_req("wrap_req2", 20);
    check("wrap_addr2", 128'(o_ddr_rd_addr), 128'h000_0040);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
